// File: rtl/light_dance_pkg.sv
// Shared definitions for the LightDance pattern sequencer.
//   state_t       : sequencer states IDLE/LOAD/SHIFT/DONE
//   mode_t        : serial-fill source codes (ones, zeros, LFSR, rotate)
//   PAT_*         : preset parallel-load patterns, selected by pat_sel
//   LFSR_SEED     : reset value of the pseudo-random generator
//   pattern_lookup: pat_sel -> 8-bit preset pattern
//   lfsr_advance  : one step of the 8-bit Fibonacci LFSR (taps 8,6,5,4)
package light_dance_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_ONES   = 2'd0,
        MODE_ZEROS  = 2'd1,
        MODE_LFSR   = 2'd2,
        MODE_ROTATE = 2'd3
    } mode_t;

    localparam logic [7:0] PAT_0     = 8'hD5;
    localparam logic [7:0] PAT_1     = 8'h81;
    localparam logic [7:0] PAT_2     = 8'hF0;
    localparam logic [7:0] PAT_3     = 8'hAA;
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    function automatic logic [7:0] pattern_lookup(input logic [1:0] sel);
        logic [7:0] pat;
        case (sel)
            2'd0:    pat = PAT_0;
            2'd1:    pat = PAT_1;
            2'd2:    pat = PAT_2;
            default: pat = PAT_3;
        endcase
        return pat;
    endfunction

    // Taps 8,6,5,4 map to bits 7,5,4,3; new bit enters at bit 0, which is
    // also the bit presented as the serial output.
    function automatic logic [7:0] lfsr_advance(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

endpackage

// File: rtl/light_dance_if.sv
// Link between the sequencer and the LightDance shift-register stage.
//   load  : parallel-load strobe          (sequencer -> LightDance)
//   pdata : pattern to parallel-load      (sequencer -> LightDance)
//   din   : serial fill bit               (sequencer -> LightDance)
//   step  : one-cycle shift strobe        (sequencer -> LightDance)
//   qdata : shift-register contents       (LightDance -> sequencer)
interface light_dance_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] pdata;
    logic             din;
    logic             step;
    logic [WIDTH-1:0] qdata;

    modport master (
        output load, pdata, din, step,
        input  qdata
    );

    modport slave (
        input  load, pdata, din, step,
        output qdata
    );
endinterface

// File: rtl/light_dance_lfsr.sv
// 8-bit Fibonacci LFSR used as the pseudo-random serial-fill source.
//   clk  : clock
//   srst : synchronous reset, loads LFSR_SEED
//   en   : advance one position this cycle
//   q    : current LFSR state (q[0] is the output bit)
module light_dance_lfsr
    import light_dance_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       en,
    output logic [7:0] q
);

    logic [7:0] q_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            q_reg <= LFSR_SEED;
        end else if (en) begin
            q_reg <= lfsr_advance(q_reg);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/light_dance_ctrl.sv
// Pattern sequencer driving the LightDance shift-register stage.
// On start it parallel-loads one of four preset patterns, then issues STEPS
// shift strobes spaced DIV clocks apart, each with a serial fill bit, and
// finishes with a one-cycle done pulse.
//   clk     : clock
//   arst    : synchronous active-high reset
//   start   : begin a sequence (honoured in IDLE only)
//   stop    : abort a running sequence (no done pulse)
//   mode    : fill source 0 ones, 1 zeros, 2 LFSR, 3 rotate (qdata MSB)
//   pat_sel : preset pattern index
//   busy    : sequence in progress (LOAD and SHIFT)
//   done    : one-cycle end-of-sequence pulse
//   ld      : light_dance_if master (load/pdata/din/step out, qdata in)
// Build option: define LIGHT_DANCE_LFSR_EN to build the LFSR; without it
// mode 2 fills with zeros, exactly like mode 1.
module light_dance_ctrl
    import light_dance_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 4,
    parameter int STEPS = 8
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [1:0]        pat_sel,
    output logic              busy,
    output logic              done,
    light_dance_if.master     ld
);

    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int STEP_W = $clog2(STEPS + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [STEP_W-1:0] STEPS_CNT = STEP_W'(STEPS);

    state_t              state_reg;
    mode_t               mode_reg;
    logic [DIV_W-1:0]    div_cnt_reg;
    logic [STEP_W-1:0]   step_cnt_reg;
    logic                load_reg;
    logic [WIDTH-1:0]    pdata_reg;
    logic                din_reg;
    logic                step_reg;
    logic                busy_reg;
    logic                done_reg;

    logic                period_end;
    logic                lfsr_bit;
    logic                src_bit;

    // The load cycle counts as the first cycle of the first step period, so
    // the first strobe lands DIV cycles after load (DIV=1: the very next one).
    assign period_end = ((state_reg == ST_LOAD) || (state_reg == ST_SHIFT)) &&
                        (div_cnt_reg == DIV_LAST);

`ifdef LIGHT_DANCE_LFSR_EN
    logic       lfsr_en;
    logic [7:0] lfsr_q;

    // Advance only when a strobe is actually issued (not on the closing
    // period that leads to DONE, and not when stop aborts).
    assign lfsr_en = period_end && !stop && (step_cnt_reg != STEPS_CNT);

    light_dance_lfsr u_lfsr (
        .clk  (clk),
        .srst (arst),
        .en   (lfsr_en),
        .q    (lfsr_q)
    );

    assign lfsr_bit = lfsr_q[0];
`else
    assign lfsr_bit = 1'b0;
`endif

    always_comb begin
        src_bit = 1'b0;
        case (mode_reg)
            MODE_ONES:   src_bit = 1'b1;
            MODE_ZEROS:  src_bit = 1'b0;
            MODE_LFSR:   src_bit = lfsr_bit;
            MODE_ROTATE: src_bit = ld.qdata[WIDTH-1];
            default:     src_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_reg    <= ST_IDLE;
            mode_reg     <= MODE_ONES;
            div_cnt_reg  <= '0;
            step_cnt_reg <= '0;
            load_reg     <= 1'b0;
            pdata_reg    <= '0;
            din_reg      <= 1'b0;
            step_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            // Strobes default low; pdata and din hold their last value.
            load_reg <= 1'b0;
            step_reg <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    div_cnt_reg  <= '0;
                    step_cnt_reg <= '0;
                    if (start && !stop) begin
                        state_reg <= ST_LOAD;
                        mode_reg  <= mode_t'(mode);
                        load_reg  <= 1'b1;
                        pdata_reg <= WIDTH'(pattern_lookup(pat_sel));
                        busy_reg  <= 1'b1;
                    end
                end
                ST_LOAD, ST_SHIFT: begin
                    if (stop) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        state_reg <= ST_SHIFT;
                        if (div_cnt_reg == DIV_LAST) begin
                            div_cnt_reg <= '0;
                            if (step_cnt_reg == STEPS_CNT) begin
                                // One extra period after the last strobe.
                                state_reg <= ST_DONE;
                                done_reg  <= 1'b1;
                                busy_reg  <= 1'b0;
                            end else begin
                                step_reg     <= 1'b1;
                                din_reg      <= src_bit;
                                step_cnt_reg <= step_cnt_reg + 1'b1;
                            end
                        end else begin
                            div_cnt_reg <= div_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign ld.load  = load_reg;
    assign ld.pdata = pdata_reg;
    assign ld.din   = din_reg;
    assign ld.step  = step_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_light_dance_ctrl.sv
module tb_light_dance_ctrl;
    import light_dance_pkg::*;

    localparam int STEPS = 8;

`ifdef LIGHT_DANCE_LFSR_EN
    localparam logic [7:0] LFSR_BITS_EXP = 8'hE5; // 1,0,1,0,0,1,1,1 from seed A5
`else
    localparam logic [7:0] LFSR_BITS_EXP = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [1:0] pat_sel = 2'd0;

    // DUT outputs, instance 0 has DIV=4, instance 1 has DIV=1
    logic       load_a  [2];
    logic [7:0] pdata_a [2];
    logic       din_a   [2];
    logic       step_a  [2];
    logic       busy_a  [2];
    logic       done_a  [2];

    // Reference model state and expected outputs
    logic [7:0] ld_q    [2];
    bit         m_run   [2];
    int         m_k     [2];
    logic [1:0] m_mode  [2];
    logic [7:0] m_lfsr  [2];
    logic       e_load  [2];
    logic [7:0] e_pdata [2];
    logic       e_din   [2];
    logic       e_step  [2];
    logic       e_busy  [2];
    logic       e_done  [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Event log for the directed literal checks
    int         ev_loads [2];
    int         ev_steps [2];
    int         ev_ones  [2];
    int         ev_done  [2];
    int         ev_gapbad[2];
    int         ev_lcyc  [2];
    int         ev_dcyc  [2];
    int         ev_last  [2];
    logic [7:0] ev_pdata [2];
    logic [7:0] ev_bits  [2];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        light_dance_if #(.WIDTH(8)) bus ();

        light_dance_ctrl #(
            .WIDTH (8),
            .DIV   ((gi == 0) ? 4 : 1),
            .STEPS (STEPS)
        ) dut (
            .clk     (clk),
            .arst    (arst),
            .start   (start),
            .stop    (stop),
            .mode    (mode),
            .pat_sel (pat_sel),
            .busy    (busy_a[gi]),
            .done    (done_a[gi]),
            .ld      (bus)
        );

        assign load_a[gi]  = bus.load;
        assign pdata_a[gi] = bus.pdata;
        assign din_a[gi]   = bus.din;
        assign step_a[gi]  = bus.step;
        assign bus.qdata   = ld_q[gi];
    end

    // Behavioural model: a run is a timeline k = cycles since the load cycle.
    // Strobe at every k that is a multiple of DIV up to STEPS*DIV, done at
    // DIV*(STEPS+1), busy while k is below that. The LightDance register is
    // driven from the expected outputs so the model stays independent.
    always @(posedge clk) begin : ref_model
        logic [7:0] q_n;
        int         kn;
        int         dv;
        int         dend;
        logic       src;
        for (int i = 0; i < 2; i++) begin
            dv   = (i == 0) ? 4 : 1;
            dend = dv * (STEPS + 1);
            if (e_load[i])      q_n = e_pdata[i];
            else if (e_step[i]) q_n = {ld_q[i][6:0], e_din[i]};
            else                q_n = ld_q[i];
            src = 1'b0;
            case (m_mode[i])
                2'd0: src = 1'b1;
                2'd1: src = 1'b0;
                2'd2: begin
`ifdef LIGHT_DANCE_LFSR_EN
                    src = m_lfsr[i][0];
`else
                    src = 1'b0;
`endif
                end
                default: src = ld_q[i][7];
            endcase
            if (arst) begin
                m_run[i]   <= 1'b0;
                m_k[i]     <= 0;
                m_mode[i]  <= 2'd0;
                m_lfsr[i]  <= 8'hA5;
                ld_q[i]    <= 8'h00;
                e_load[i]  <= 1'b0;
                e_pdata[i] <= 8'h00;
                e_din[i]   <= 1'b0;
                e_step[i]  <= 1'b0;
                e_busy[i]  <= 1'b0;
                e_done[i]  <= 1'b0;
            end else begin
                ld_q[i]   <= q_n;
                e_load[i] <= 1'b0;
                e_step[i] <= 1'b0;
                e_done[i] <= 1'b0;
                if (!m_run[i]) begin
                    if (start && !stop) begin
                        m_run[i]   <= 1'b1;
                        m_k[i]     <= 0;
                        m_mode[i]  <= mode;
                        e_load[i]  <= 1'b1;
                        e_pdata[i] <= pattern_lookup(pat_sel);
                        e_busy[i]  <= 1'b1;
                    end
                end else if (m_k[i] < dend && stop) begin
                    m_run[i]  <= 1'b0;
                    e_busy[i] <= 1'b0;
                end else if (m_k[i] == dend) begin
                    m_run[i] <= 1'b0;
                end else begin
                    kn = m_k[i] + 1;
                    m_k[i]    <= kn;
                    e_busy[i] <= (kn < dend);
                    e_done[i] <= (kn == dend);
                    if ((kn % dv == 0) && (kn / dv <= STEPS)) begin
                        e_step[i] <= 1'b1;
                        e_din[i]  <= src;
                        m_lfsr[i] <= lfsr_advance(m_lfsr[i]);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h", nm, i, cyc, got, exp);
        end
    endtask

    task automatic clear_ev();
        for (int i = 0; i < 2; i++) begin
            ev_loads[i] = 0; ev_steps[i] = 0; ev_ones[i] = 0; ev_done[i] = 0;
            ev_gapbad[i] = 0; ev_lcyc[i] = 0; ev_dcyc[i] = 0; ev_last[i] = 0;
            ev_pdata[i] = 8'h00; ev_bits[i] = 8'h00;
        end
    endtask

    // One cycle: compare outputs at the falling edge, log events, then apply
    // the inputs for the next rising edge.
    task automatic drive(input logic st, input logic sp, input logic [1:0] md,
                         input logic [1:0] ps, input logic r);
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            chk("load",  i, 32'(load_a[i]),  32'(e_load[i]));
            chk("pdata", i, 32'(pdata_a[i]), 32'(e_pdata[i]));
            chk("din",   i, 32'(din_a[i]),   32'(e_din[i]));
            chk("step",  i, 32'(step_a[i]),  32'(e_step[i]));
            chk("busy",  i, 32'(busy_a[i]),  32'(e_busy[i]));
            chk("done",  i, 32'(done_a[i]),  32'(e_done[i]));
            if (load_a[i]) begin
                ev_loads[i]++;
                ev_lcyc[i]  = cyc;
                ev_last[i]  = cyc;
                ev_pdata[i] = pdata_a[i];
            end
            if (step_a[i]) begin
                if (cyc - ev_last[i] != ((i == 0) ? 4 : 1)) ev_gapbad[i]++;
                ev_last[i] = cyc;
                if (ev_steps[i] < 8) ev_bits[i][ev_steps[i]] = din_a[i];
                if (din_a[i]) ev_ones[i]++;
                ev_steps[i]++;
            end
            if (done_a[i]) begin
                ev_done[i]++;
                ev_dcyc[i] = cyc;
            end
        end
        start = st; stop = sp; mode = md; pat_sel = ps; arst = r;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, mode, pat_sel, 1'b0);
    endtask

    initial begin
        bit found;
        clear_ev();
        repeat (3) drive(1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        drive(1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy",  i, 32'(busy_a[i]),  32'd0);
            chk("rst_pdata", i, 32'(pdata_a[i]), 32'd0);
            chk("rst_load",  i, 32'(load_a[i]),  32'd0);
        end
        $display("reset: outputs idle");

        // Basic run: pattern 0, fill with ones
        clear_ev();
        drive(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        idle(45);
        chk("basic_steps",  0, 32'(ev_steps[0]), 32'd8);
        chk("basic_ones",   0, 32'(ev_ones[0]),  32'd8);
        chk("basic_pdata",  0, 32'(ev_pdata[0]), 32'hD5);
        chk("basic_doneat", 0, 32'(ev_dcyc[0] - ev_lcyc[0]), 32'd36);
        chk("basic_gap",    0, 32'(ev_gapbad[0]), 32'd0);
        chk("basic_busy",   0, 32'(busy_a[0]), 32'd0);
        chk("div1_steps",   1, 32'(ev_steps[1]), 32'd8);
        chk("div1_doneat",  1, 32'(ev_dcyc[1] - ev_lcyc[1]), 32'd9);
        chk("div1_gap",     1, 32'(ev_gapbad[1]), 32'd0);
        $display("run: pat0 mode0 steps=%0d done_after=%0d", ev_steps[0], ev_dcyc[0] - ev_lcyc[0]);

        // Reset mid-shift aborts without done
        drive(1'b1, 1'b0, 2'd0, 2'd1, 1'b0);
        idle(15);
        clear_ev();
        drive(1'b0, 1'b0, 2'd0, 2'd1, 1'b1);
        drive(1'b0, 1'b0, 2'd0, 2'd1, 1'b1);
        drive(1'b0, 1'b0, 2'd0, 2'd1, 1'b0);
        idle(40);
        chk("rstmid_done",  0, 32'(ev_done[0]),  32'd0);
        chk("rstmid_steps", 0, 32'(ev_steps[0]), 32'd0);
        chk("rstmid_pdata", 0, 32'(pdata_a[0]),  32'd0);
        $display("run: reset mid-shift, done=%0d", ev_done[0]);

        // Rotate with the LightDance register in the loop
        clear_ev();
        drive(1'b1, 1'b0, 2'd3, 2'd3, 1'b0);
        idle(45);
        chk("rot_pdata", 0, 32'(ev_pdata[0]), 32'hAA);
        chk("rot_steps", 0, 32'(ev_steps[0]), 32'd8);
        chk("rot_qdata", 0, 32'(ld_q[0]),     32'hAA);
        $display("run: rotate pat3 qdata=%0h", ld_q[0]);

        // LFSR fill straight after reset
        drive(1'b0, 1'b0, 2'd2, 2'd0, 1'b1);
        drive(1'b0, 1'b0, 2'd2, 2'd0, 1'b1);
        clear_ev();
        drive(1'b1, 1'b0, 2'd2, 2'd2, 1'b0);
        idle(45);
        chk("lfsr_bits", 0, 32'(ev_bits[0]), 32'(LFSR_BITS_EXP));
        chk("lfsr_bits", 1, 32'(ev_bits[1]), 32'(LFSR_BITS_EXP));
        $display("run: mode2 bits=%0h", ev_bits[0]);

        // Stop after the third strobe
        clear_ev();
        drive(1'b1, 1'b0, 2'd0, 2'd2, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            drive(1'b0, 1'b0, 2'd0, 2'd2, 1'b0);
            if (ev_steps[0] == 3) found = 1'b1;
        end
        if (!found) begin
            errors++;
            $display("FAIL stop_wait inst=0 got=%0d steps exp=3 within 100 cycles", ev_steps[0]);
        end
        stop = 1'b1;
        drive(1'b0, 1'b0, 2'd0, 2'd2, 1'b0);
        chk("stop_busy", 0, 32'(busy_a[0]), 32'd0);
        idle(40);
        chk("stop_steps", 0, 32'(ev_steps[0]), 32'd3);
        chk("stop_done",  0, 32'(ev_done[0]),  32'd0);
        $display("run: stopped after %0d steps", ev_steps[0]);

        // start and stop together in IDLE
        clear_ev();
        drive(1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
        idle(10);
        chk("startstop_load", 0, 32'(ev_loads[0]), 32'd0);
        chk("startstop_load", 1, 32'(ev_loads[1]), 32'd0);
        $display("run: start+stop ignored, loads=%0d", ev_loads[0]);

        // start re-pulsed while running
        clear_ev();
        drive(1'b1, 1'b0, 2'd1, 2'd1, 1'b0);
        idle(9);
        drive(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        idle(9);
        drive(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        idle(30);
        chk("restart_loads", 0, 32'(ev_loads[0]), 32'd1);
        chk("restart_steps", 0, 32'(ev_steps[0]), 32'd8);
        chk("restart_done",  0, 32'(ev_done[0]),  32'd1);
        chk("restart_ones",  0, 32'(ev_ones[0]),  32'd0);
        $display("run: restart ignored, steps=%0d", ev_steps[0]);

        // Randomized traffic against the model
        for (int n = 0; n < 2500; n++) begin
            drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 499) == 0));
        end
        idle(50);
        $display("random: %0d cycles", cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
